// File: rtl/redirect_pkg.sv
// Shared types and constants for the way0 fetch-redirect arbiter.
package redirect_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, FLUSH} state_e;

  localparam int unsigned REQ_TRAP    = 0;
  localparam int unsigned REQ_BRU     = 1;
  localparam int unsigned REQ_DEC     = 2;
  localparam int unsigned REQ_BPU     = 3;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned FCNT_W      = 4;

endpackage

// File: rtl/prio_enc.sv
// Fixed-priority encoder: index 0 wins; one-hot grant plus any-request flag.
module prio_enc #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] grant_c,
  output logic         valid_c
);

  // Isolate the lowest set bit.
  assign grant_c = req & (~req + N'(1));
  assign valid_c = |req;

endmodule

// File: rtl/redirect_arbiter_way0.sv
// Issues one fetch redirect at a time to the way0 PC unit and holds a
// front-end flush until the jump is consumed plus a short drain window.
module redirect_arbiter_way0
  import redirect_pkg::*;
#(
  parameter int unsigned NUM_REQ      = NUM_REQ_DEF,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  output logic [NUM_REQ-1:0]        ack_o,
  output logic                      misalign_o,
  input  logic                      pcu_ready_i,
  output logic                      jump_flag_o,
  output logic [ADDR_W-1:0]         jump_addr_o,
  output logic                      jump_slot_o,
  output logic                      flush_o,
  output logic                      busy_o,
  output logic [CNT_W-1:0]          redirect_cnt_o
);

  state_e              state;
  logic [FCNT_W-1:0]   flush_cnt;
  logic [NUM_REQ-1:0]  grant_c;
  logic                grant_valid_c;
  logic [ADDR_W-1:0]   sel_addr_c;

  prio_enc #(.N(NUM_REQ)) u_prio_enc (
    .req     (req_i),
    .grant_c (grant_c),
    .valid_c (grant_valid_c)
  );

  // Target of the granted source (grant is one-hot, so OR-reduce is a mux).
  always_comb begin
    sel_addr_c = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_c[k]) sel_addr_c = sel_addr_c | addr_i[ADDR_W*k +: ADDR_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      flush_cnt      <= '0;
      ack_o          <= '0;
      misalign_o     <= 1'b0;
      jump_flag_o    <= 1'b0;
      jump_addr_o    <= '0;
      jump_slot_o    <= 1'b0;
      flush_o        <= 1'b0;
      busy_o         <= 1'b0;
      redirect_cnt_o <= '0;
    end else begin
      ack_o       <= '0;
      misalign_o  <= 1'b0;
      jump_flag_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_valid_c) begin
            ack_o <= grant_c;
            if (sel_addr_c[1:0] != 2'b00) begin
              misalign_o <= 1'b1;
            end else begin
              jump_flag_o <= 1'b1;
              jump_addr_o <= {sel_addr_c[ADDR_W-1:3], 3'b000};
              jump_slot_o <= sel_addr_c[2];
              flush_o     <= 1'b1;
              busy_o      <= 1'b1;
              if (redirect_cnt_o != '1) redirect_cnt_o <= redirect_cnt_o + CNT_W'(1);
              state       <= WAIT;
            end
          end
        end
        WAIT: begin
          // The PC unit may consume the jump in the very cycle it is flagged.
          if (pcu_ready_i) begin
            if (FLUSH_CYCLES == 0) begin
              state   <= IDLE;
              flush_o <= 1'b0;
              busy_o  <= 1'b0;
            end else begin
              state     <= FLUSH;
              flush_cnt <= FCNT_W'(FLUSH_CYCLES - 1);
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == '0) begin
            state   <= IDLE;
            flush_o <= 1'b0;
            busy_o  <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - FCNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_redirect_arbiter_way0.sv
// Bench for redirect_arbiter_way0: directed scenarios plus random traffic,
// checked against a timeline model of issue / consume / flush-release.
module tb_redirect_arbiter_way0;

  localparam int FC = 2;

  logic         clk;
  logic         reset;
  logic [3:0]   req;
  logic [127:0] addr_flat;
  logic [3:0]   ack;
  logic         misalign;
  logic         ready;
  logic         jump_flag;
  logic [31:0]  jump_addr;
  logic         jump_slot;
  logic         flush;
  logic         busy;
  logic [15:0]  cnt;

  logic         reset_b;
  logic [3:0]   req_b;
  logic [127:0] addr_b;
  logic [3:0]   ack_b;
  logic         misalign_b;
  logic         ready_b;
  logic         jump_flag_b;
  logic [31:0]  jump_addr_b;
  logic         jump_slot_b;
  logic         flush_b;
  logic         busy_b;
  logic [3:0]   cnt_b;

  redirect_arbiter_way0 #(.NUM_REQ(4), .FLUSH_CYCLES(FC), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .req_i(req), .addr_i(addr_flat), .ack_o(ack),
    .misalign_o(misalign), .pcu_ready_i(ready), .jump_flag_o(jump_flag),
    .jump_addr_o(jump_addr), .jump_slot_o(jump_slot), .flush_o(flush),
    .busy_o(busy), .redirect_cnt_o(cnt)
  );

  redirect_arbiter_way0 #(.NUM_REQ(4), .FLUSH_CYCLES(0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset_b), .req_i(req_b), .addr_i(addr_b), .ack_o(ack_b),
    .misalign_o(misalign_b), .pcu_ready_i(ready_b), .jump_flag_o(jump_flag_b),
    .jump_addr_o(jump_addr_b), .jump_slot_o(jump_slot_b), .flush_o(flush_b),
    .busy_o(busy_b), .redirect_cnt_o(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Model state: busy flag and the edge at which the unit returns to idle.
  int          e = 0;
  bit          m_busy = 0;
  int          m_release = -1;
  logic [3:0]  e_ack;
  logic        e_mis, e_flag, e_slot, e_flush, e_busy;
  logic [31:0] e_addr;
  logic [15:0] e_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_addr(input int k, input logic [31:0] v);
    addr_flat[32*k +: 32] = v;
  endtask

  // Drive one cycle of inputs, advance an edge, predict and compare outputs.
  task automatic cycle(input logic rst, input logic [3:0] rq, input logic rdy);
    int g;
    logic [31:0] a;
    reset = rst; req = rq; ready = rdy;
    @(posedge clk);
    #1;
    e_ack = '0; e_mis = 1'b0; e_flag = 1'b0;
    if (rst) begin
      m_busy = 0; e_addr = '0; e_slot = 1'b0; e_flush = 1'b0; e_busy = 1'b0; e_cnt = '0;
    end else if (!m_busy) begin
      if (rq != 4'b0000) begin
        g = -1;
        for (int i = 3; i >= 0; i--) if (rq[i]) g = i;
        a = addr_flat[32*g +: 32];
        e_ack = 4'(1 << g);
        if (a[1:0] != 2'b00) begin
          e_mis = 1'b1;
        end else begin
          e_flag = 1'b1; e_addr = {a[31:3], 3'b000}; e_slot = a[2];
          e_flush = 1'b1; e_busy = 1'b1;
          if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
          m_busy = 1; m_release = -1;
        end
      end
    end else begin
      if (m_release < 0 && rdy) m_release = e + FC;
      if (m_release >= 0 && e >= m_release) begin
        m_busy = 0; e_flush = 1'b0; e_busy = 1'b0;
      end
    end
    e++;
    chk("ack", 32'(ack), 32'(e_ack));
    chk("misalign", 32'(misalign), 32'(e_mis));
    chk("jump_flag", 32'(jump_flag), 32'(e_flag));
    chk("jump_addr", jump_addr, e_addr);
    chk("jump_slot", 32'(jump_slot), 32'(e_slot));
    chk("flush", 32'(flush), 32'(e_flush));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("cnt", 32'(cnt), 32'(e_cnt));
  endtask

  initial begin
    int flush_hi, spacing, trap_k;
    logic [3:0] rq;
    reset = 1'b1; req = '0; ready = 1'b0; addr_flat = '0;
    reset_b = 1'b1; req_b = '0; ready_b = 1'b0; addr_b = '0;
    e_addr = '0; e_cnt = '0;

    cycle(1'b1, 4'b0000, 1'b0);
    cycle(1'b1, 4'b0000, 1'b0);
    reset_b = 1'b0;
    chk("reset_cnt_b", 32'(cnt_b), 32'd0);

    // Branch redirect to slot 1 of a fetch pair.
    set_addr(1, 32'h0000_1004);
    cycle(1'b0, 4'b0010, 1'b1);
    flush_hi = int'(flush);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 4'b0000, 1'b1);
      flush_hi += int'(flush);
    end
    chk("flush_len", 32'(flush_hi), 32'd3);
    chk("cnt_after_1", 32'(cnt), 32'd1);
    chk("addr_1000", jump_addr, 32'h0000_1000);
    chk("slot_1", 32'(jump_slot), 32'd1);

    // Simultaneous requests, then the loser is served after the flush.
    set_addr(0, 32'h8000_0000);
    set_addr(3, 32'h0000_0010);
    cycle(1'b0, 4'b1011, 1'b1);
    chk("trap_first", 32'(ack), 32'h1);
    rq = 4'b1010;
    spacing = 0;
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b0, rq, 1'b1);
      if (jump_flag && spacing == 0) begin
        spacing = k;
        rq = 4'b0000;
      end
    end
    chk("b2b_spacing", 32'(spacing), 32'd4);

    // Misaligned trap target is acked and dropped.
    set_addr(0, 32'h0000_2002);
    cycle(1'b0, 4'b0001, 1'b1);
    chk("misalign_pulse", 32'(misalign), 32'd1);
    cycle(1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);

    // PC unit stalls; a trap arriving meanwhile waits for the idle cycle.
    set_addr(2, 32'h0000_3000);
    set_addr(0, 32'h0000_5000);
    cycle(1'b0, 4'b0100, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 4'b0001, 1'b0);
    rq = 4'b0001;
    trap_k = 0;
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b0, rq, 1'b1);
      if (ack[0] && trap_k == 0) begin
        trap_k = k;
        rq = 4'b0000;
      end
    end
    chk("trap_after_stall", 32'(trap_k), 32'd4);
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0000, 1'b1);

    // Reset while waiting, with a trap pending across it.
    cycle(1'b0, 4'b0100, 1'b0);
    cycle(1'b0, 4'b0001, 1'b0);
    cycle(1'b1, 4'b0001, 1'b0);
    cycle(1'b0, 4'b0001, 1'b1);
    chk("trap_after_reset", 32'(ack), 32'h1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 4'b0000, 1'b1);

    // Random traffic: requests held until acked, occasional reset.
    rq = 4'b0000;
    for (int n = 0; n < 300; n++) begin
      logic rst;
      for (int k = 0; k < 4; k++) begin
        if (!rq[k] && $urandom_range(7) == 0) begin
          logic [31:0] a;
          a = $urandom;
          if ($urandom_range(3) != 0) a[1:0] = 2'b00;
          set_addr(k, a);
          rq[k] = 1'b1;
        end
      end
      rst = ($urandom_range(63) == 0);
      cycle(rst, rq, 1'(($urandom_range(1))));
      rq = rq & ~e_ack;
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 4'b0000, 1'b1);

    // Zero-drain build: one jump every two cycles, counter saturating at 15.
    addr_b[127:96] = 32'h0000_4000;
    req_b = 4'b1000;
    ready_b = 1'b1;
    for (int k = 0; k < 40; k++) begin
      int exp_cnt;
      @(posedge clk);
      #1;
      exp_cnt = (k / 2 + 1 > 15) ? 15 : k / 2 + 1;
      chk("b_flag", 32'(jump_flag_b), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("b_cnt", 32'(cnt_b), 32'(exp_cnt));
    end
    req_b = 4'b0000;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/redirect_arbiter_way0.md
Name: redirect_arbiter_way0

Overview:
Arbitrates fetch-redirect requests from up to NUM_REQ sources (trap unit, branch unit, decode-stage jump, branch predictor) onto the single jump-flag/jump-address interface of the way0 PC unit. It issues one redirect at a time and waits until the PC unit has consumed it, because the PC unit's one-entry jump buffer cannot absorb a second jump. It then asserts a flush window so the front end discards wrong-path fetch packets. It sits between the back-end redirect sources and the way0 PC unit.

Parameters:
NUM_REQ, 4, number of redirect requesters; index 0 has the highest priority.
FLUSH_CYCLES, 2, extra cycles flush_o stays high after the PC unit consumes the jump; legal range 0..15.
CNT_W, 16, width of the saturating redirect counter.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
req_i  in  NUM_REQ  per-source redirect request, level; held until acked.
addr_i  in  NUM_REQ*32  per-source target; slice k is bits [32k+31:32k].
ack_o  out  NUM_REQ  one-hot, one-cycle pulse: the request was taken.
misalign_o  out  1  one-cycle pulse: the granted target had addr[1:0]!=0 and was dropped.
pcu_ready_i  in  1  ready from the way0 PC unit; the jump is consumed on the first cycle it is high.
jump_flag_o  out  1  one-cycle pulse to the PC unit jump-flag input.
jump_addr_o  out  32  target, 8-byte aligned, held stable from issue until return to IDLE.
jump_slot_o  out  1  granted addr[2]; set means the target is the second instruction of the fetch pair.
flush_o  out  1  front-end flush, high in WAIT and FLUSH.
busy_o  out  1  state != IDLE.
redirect_cnt_o  out  CNT_W  count of issued redirects, saturating.

Behaviour:
- Reset (synchronous, reset=1 at an edge):
  - state=IDLE.
  - ack_o, misalign_o, jump_flag_o, jump_slot_o, flush_o, busy_o all 0.
  - jump_addr_o=0, redirect_cnt_o=0, flush counter=0.
  - Reset mid-operation drops the pending redirect with no ack.
- Fixed priority: the grant g is the lowest index with req_i[g]=1. req_i is sampled only in IDLE.
- IDLE, any req_i set, at edge t:
  - If addr[1:0]!=0: in cycle t+1 pulse ack_o[g] and misalign_o; stay IDLE; no jump_flag_o.
  - Otherwise, in cycle t+1:
    - jump_flag_o=1 for exactly one cycle, and ack_o[g]=1 in the same cycle.
    - jump_addr_o={addr[31:3],3'b000} and jump_slot_o=addr[2].
    - flush_o=1; redirect_cnt_o increments, holding at all-ones.
    - state=WAIT.
- WAIT:
  - In the first cycle with pcu_ready_i=1 (this may be the jump_flag_o cycle itself): if FLUSH_CYCLES=0, next state=IDLE; otherwise next state=FLUSH with counter=FLUSH_CYCLES-1.
  - If pcu_ready_i=0, stay in WAIT indefinitely, outputs held.
- FLUSH:
  - flush_o=1; the counter decrements each cycle.
  - When counter==0, next state=IDLE, and flush_o falls in the IDLE cycle.
- Requests arriving in WAIT or FLUSH are not acked; they are arbitrated in the first IDLE cycle. No preemption of an issued redirect.
- Requesters whose instruction was killed by flush_o deassert req_i themselves. A trap held across the flush wins the next arbitration.
- Back-to-back redirects: minimum spacing between jump_flag_o pulses is FLUSH_CYCLES+2 cycles when pcu_ready_i is held high.
- Simultaneous req_i and reset: reset wins.
- All outputs are registered; there is no combinational path from req_i to ack_o.

Decomposition:
- Package redirect_pkg:
  - state enum {IDLE, WAIT, FLUSH}.
  - Source index constants REQ_TRAP=0, REQ_BRU=1, REQ_DEC=2, REQ_BPU=3.
  - Default NUM_REQ.
- Sub-module prio_enc: a parameterised fixed-priority encoder returning a one-hot grant and a valid bit.
- The FSM, counters and address register stay in the top module.

Test Plan:
- req_i=4'b0010, addr1=0x0000_1004, pcu_ready_i=1 -> next cycle: jump_flag_o=1, ack_o=4'b0010, jump_addr_o=0x1000, jump_slot_o=1; flush_o high for 3 cycles; busy_o falls after FLUSH; redirect_cnt_o=1.
- req_i=4'b1011 all at once, addr0=0x8000_0000 -> ack_o=4'b0001, jump_addr_o=0x8000_0000. Then hold req_i=4'b1010 -> next ack_o=4'b0010 issued exactly FLUSH_CYCLES+2=4 cycles after the first jump_flag_o.
- req_i=4'b0001, addr0=0x0000_2002 -> ack_o=4'b0001 with misalign_o=1 the same cycle; jump_flag_o stays 0; busy_o stays 0.
- pcu_ready_i=0 for 5 cycles after issue -> WAIT held, flush_o=1, jump_addr_o stable, req_i=4'b0001 not acked; pcu_ready_i=1 -> FLUSH, then the trap is granted.
- reset=1 one cycle while in WAIT -> next cycle all outputs 0, state IDLE, redirect_cnt_o=0; a request pending at reset is re-arbitrated afterwards.
- FLUSH_CYCLES=0 build, pcu_ready_i=1, continuous req_i=4'b1000 -> jump_flag_o pulses every 2 cycles. With CNT_W=4, redirect_cnt_o saturates at 15.
